// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// digit width, FSM state encoding and the all-off segment pattern.
package bcd_pkg;

   localparam int DIGIT_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   // Segment pattern a downstream decoder drives for a blanked digit
   localparam logic [6:0] BLANK_SEG = 7'b1111111;

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle between the adder stage, the converter and the
// 7-segment decoders. Optional BIN2BCD_BLANK_EN adds the leading-zero blank mask.
interface bin2bcd_seq_if
   import bcd_pkg::*;
#(
   parameter int WIDTH  = 9,
   parameter int DIGITS = 3
);

   logic                        start;
   logic [WIDTH-1:0]            bin_in;
   logic                        busy;
   logic                        done;
   logic [DIGIT_W*DIGITS-1:0]   bcd_out;
`ifdef BIN2BCD_BLANK_EN
   logic [DIGITS-1:0]           blank;

   modport master (output start, bin_in, input busy, done, bcd_out, blank);
   modport slave  (input start, bin_in, output busy, done, bcd_out, blank);
`else
   modport master (output start, bin_in, input busy, done, bcd_out);
   modport slave  (input start, bin_in, output busy, done, bcd_out);
`endif

endinterface

// File: rtl/bcd_add3.sv
// Double-dabble digit corrector: a BCD digit of 5 or more gets 3 added so
// the following left shift carries correctly into the next decade.
module bcd_add3
   import bcd_pkg::*;
(
   input  logic [DIGIT_W-1:0] d,
   output logic [DIGIT_W-1:0] q
);

   assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock).
// Optional leading-zero blank mask output enabled by BIN2BCD_BLANK_EN.
module bin2bcd_seq
   import bcd_pkg::*;
#(
   parameter int WIDTH  = 9,
   parameter int DIGITS = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   bin2bcd_seq_if.slave  bus
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam int BCD_W = DIGIT_W * DIGITS;

   generate
      if (10**DIGITS <= 2**WIDTH) begin : g_param_check
         $error("bin2bcd_seq: DIGITS=%0d cannot hold 2**WIDTH-1 for WIDTH=%0d", DIGITS, WIDTH);
      end
   endgenerate

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   shreg_q;
   logic [BCD_W-1:0]   scratch_q;
   logic [BCD_W-1:0]   corr;
   logic [BCD_W-1:0]   scratch_nxt;
   logic [BCD_W-1:0]   bcd_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               accept;
   logic               last;
   logic               unused_corr_msb;

   for (genvar i = 0; i < DIGITS; i++) begin : g_add3
      bcd_add3 u_add3 (
         .d (scratch_q[i*DIGIT_W +: DIGIT_W]),
         .q (corr[i*DIGIT_W +: DIGIT_W])
      );
   end

   // Corrected scratch shifted left with the binary MSB entering at bit 0;
   // the top corrected bit falls off, which the parameter check makes safe.
   assign scratch_nxt     = {corr[BCD_W-2:0], shreg_q[WIDTH-1]};
   assign unused_corr_msb = corr[BCD_W-1];

   assign accept = bus.start && ((state_q == IDLE) || (state_q == DONE));
   assign last   = (state_q == SHIFT) && (cnt_q == CNT_W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = SHIFT;
         SHIFT:   if (cnt_q == CNT_W'(1)) state_d = DONE;
         DONE:    state_d = bus.start ? SHIFT : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg_q   <= '0;
         scratch_q <= '0;
         cnt_q     <= '0;
         bcd_q     <= '0;
      end else if (accept) begin
         shreg_q   <= bus.bin_in;
         scratch_q <= '0;
         cnt_q     <= CNT_W'(WIDTH);
      end else if (state_q == SHIFT) begin
         shreg_q   <= {shreg_q[WIDTH-2:0], 1'b0};
         scratch_q <= scratch_nxt;
         cnt_q     <= cnt_q - CNT_W'(1);
         if (last) bcd_q <= scratch_nxt;
      end
   end

   assign bus.busy    = (state_q == SHIFT);
   assign bus.done    = (state_q == DONE);
   assign bus.bcd_out = bcd_q;

`ifdef BIN2BCD_BLANK_EN
   logic [DIGITS-1:0] blank_q;
   logic [DIGITS-1:0] blank_nxt;
   logic              zero_run;

   // A digit blanks only while every more-significant digit is also zero
   always_comb begin
      blank_nxt = '0;
      zero_run  = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         zero_run     = zero_run && (scratch_nxt[i*DIGIT_W +: DIGIT_W] == '0);
         blank_nxt[i] = zero_run;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    blank_q <= '0;
      else if (last) blank_q <= blank_nxt;
   end

   assign bus.blank = blank_q;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed steps plus full input sweep,
// results checked against a decimal reference through a scoreboard queue.
module tb_bin2bcd_seq;
   import bcd_pkg::*;

   localparam int WIDTH  = 9;
   localparam int DIGITS = 3;

   typedef struct packed {
      logic [11:0] bcd;
      logic [2:0]  blank;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks   = 0;
   int   failures = 0;
   int   done_cnt = 0;
   exp_t sb[$];

   bin2bcd_seq_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

   bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic exp_t model(input int v);
      exp_t e;
      int d0, d1, d2;
      d0 = v % 10;
      d1 = (v / 10) % 10;
      d2 = (v / 100) % 10;
      e.bcd      = {d2[3:0], d1[3:0], d0[3:0]};
      e.blank[0] = 1'b0;
      e.blank[2] = (d2 == 0);
      e.blank[1] = (d2 == 0) && (d1 == 0);
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every done pops one expectation
   always @(negedge clk) begin
      if (rst_n === 1'b1 && bus.done === 1'b1) begin
         exp_t e;
         logic digits_ok;
         done_cnt++;
         if (sb.size() == 0) begin
            chk("spurious_done", {31'd0, bus.done}, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("bcd_out", {20'd0, bus.bcd_out}, {20'd0, e.bcd});
`ifdef BIN2BCD_BLANK_EN
            chk("blank", {29'd0, bus.blank}, {29'd0, e.blank});
`endif
            digits_ok = 1'b1;
            for (int i = 0; i < DIGITS; i++)
               if (bus.bcd_out[i*4 +: 4] > 4'd9) digits_ok = 1'b0;
            chk("digit_range", {31'd0, digits_ok}, 32'd1);
         end
      end
   end

   task automatic start_pulse(input int v, input bit push);
      bus.start  = 1'b1;
      bus.bin_in = v[WIDTH-1:0];
      if (push) sb.push_back(model(v));
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   task automatic wait_done(output int lat, output int bcnt);
      bit seen;
      lat  = 0;
      bcnt = 0;
      seen = 1'b0;
      while (!seen && lat <= 40) begin
         @(negedge clk);
         lat++;
         if (bus.busy === 1'b1) bcnt++;
         if (bus.done === 1'b1) seen = 1'b1;
      end
      if (!seen) chk("done_timeout", {31'd0, bus.done}, 32'd1);
   endtask

   initial begin
      int lat, bcnt, d0;
      bus.start  = 1'b0;
      bus.bin_in = '0;
      $display("blank segment pattern %b", BLANK_SEG);

      // Reset with start held high: must be ignored
      bus.start  = 1'b1;
      bus.bin_in = 9'd5;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_done", {31'd0, bus.done}, 32'd0);
      chk("rst_bcd", {20'd0, bus.bcd_out}, 32'd0);
`ifdef BIN2BCD_BLANK_EN
      chk("rst_blank", {29'd0, bus.blank}, 32'd0);
`endif
      bus.start = 1'b0;
      rst_n     = 1'b1;
      @(posedge clk);
      #1;
      chk("idle_after_rst", {31'd0, bus.busy}, 32'd0);

      // Zero input
      start_pulse(0, 1'b1);
      wait_done(lat, bcnt);
      chk("lat_zero", lat, 32'd10);

      // Maximum sum, busy exactly 9 cycles, single-cycle done
      @(posedge clk);
      #1;
      start_pulse(510, 1'b1);
      chk("busy_after_start", {31'd0, bus.busy}, 32'd1);
      wait_done(lat, bcnt);
      chk("lat_510", lat, 32'd10);
      chk("busy_cycles_510", bcnt, 32'd9);
      @(negedge clk);
      chk("done_single_cycle", {31'd0, bus.done}, 32'd0);

      // Start during busy is ignored, bin_in change has no effect
      @(posedge clk);
      #1;
      d0 = done_cnt;
      start_pulse(255, 1'b1);
      @(posedge clk);
      #1;
      start_pulse(7, 1'b0);
      wait_done(lat, bcnt);
      repeat (15) @(negedge clk);
      chk("one_done_255", done_cnt - d0, 32'd1);
      chk("hold_255", {20'd0, bus.bcd_out}, 32'h255);

      // Back-to-back: new start in the DONE cycle
      @(posedge clk);
      #1;
      start_pulse(300, 1'b1);
      wait_done(lat, bcnt);
      start_pulse(100, 1'b1);
      wait_done(lat, bcnt);
      chk("lat_b2b", lat, 32'd10);
      chk("b2b_bcd", {20'd0, bus.bcd_out}, 32'h100);

      // Reset abandons a running conversion
      @(posedge clk);
      #1;
      start_pulse(9, 1'b1);
      wait_done(lat, bcnt);
      @(posedge clk);
      #1;
      start_pulse(42, 1'b1);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
      chk("midrst_done", {31'd0, bus.done}, 32'd0);
      chk("midrst_bcd", {20'd0, bus.bcd_out}, 32'd0);
      sb.delete();
      d0 = done_cnt;
      bus.start = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      bus.start = 1'b0;
      rst_n     = 1'b1;
      repeat (15) @(negedge clk);
      chk("no_done_after_rst", done_cnt - d0, 32'd0);
      chk("bcd_zero_after_rst", {20'd0, bus.bcd_out}, 32'd0);
      @(posedge clk);
      #1;
      start_pulse(42, 1'b1);
      wait_done(lat, bcnt);
      chk("lat_42", lat, 32'd10);

      // Full sweep
      for (int v = 0; v < 512; v++) begin
         @(posedge clk);
         #1;
         start_pulse(v, 1'b1);
         wait_done(lat, bcnt);
         chk("sweep_lat", lat, 32'd10);
      end
      repeat (3) @(negedge clk);
      chk("sb_empty", sb.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
